// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the BRAM bus-side controller.
//   state_t   : controller FSM encoding
//   FULL_MASK : byte-write mask that selects a straight-through word write
//   BYTE_W    : width of one byte lane
package bram_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR_ISSUE,
      RMW_RD,
      RMW_MERGE
   } state_t;

   localparam logic [3:0] FULL_MASK = 4'b1111;
   localparam int         BYTE_W    = 8;

endpackage

// File: rtl/bram_byte_merge.sv
// Combinational per-byte-lane merge of new store data over old word data.
// Lane i takes new_data when mask[i] is set, otherwise keeps old_data.
//   old_data : word previously held in memory
//   new_data : CPU store data, byte lanes aligned
//   mask     : per-lane write enables
//   merged   : resulting word
module bram_byte_merge
   import bram_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]        old_data,
   input  logic [DATA_W-1:0]        new_data,
   input  logic [DATA_W/BYTE_W-1:0] mask,
   output logic [DATA_W-1:0]        merged
);

   always_comb begin
      merged = old_data;
      for (int i = 0; i < DATA_W/BYTE_W; i++) begin
         if (mask[i]) begin
            merged[i*BYTE_W +: BYTE_W] = new_data[i*BYTE_W +: BYTE_W];
         end
      end
   end

endmodule

// File: rtl/bram_rmw_ctrl.sv
// Bus-side controller in front of a small word-wide BRAM. Reads take two
// busy cycles, full-word stores one, and partial-byte stores are turned
// into a read-modify-write (read, merge, write) with three busy cycles.
// Every output is registered; outputs are computed from the next state.
//   clk, resetn          : clock, asynchronous active-low reset
//   sel                  : address decode hit for this RAM
//   mem_addr/wdata/wmask : CPU request (wmask != 0 means write)
//   mem_rstrb            : one-cycle read request
//   mem_rdata            : read data, held until the next read completes
//   mem_rbusy/mem_wbusy  : read / write in progress
//   bram_addr            : word-aligned byte address to the BRAM
//   bram_cs/rd/wr        : BRAM strobes
//   bram_wdata           : word written to the BRAM
//   bram_rdata           : BRAM read data, valid the cycle after cs&rd
module bram_rmw_ctrl
   import bram_ctrl_pkg::*;
#(
   parameter int ADDR_WORDS_LOG2 = 5,
   parameter int DATA_W          = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     sel,
   input  logic [31:0]              mem_addr,
   input  logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W/BYTE_W-1:0] mem_wmask,
   input  logic                     mem_rstrb,
   output logic [DATA_W-1:0]        mem_rdata,
   output logic                     mem_rbusy,
   output logic                     mem_wbusy,
   output logic [31:0]              bram_addr,
   output logic                     bram_cs,
   output logic                     bram_rd,
   output logic                     bram_wr,
   output logic [DATA_W-1:0]        bram_wdata,
   input  logic [DATA_W-1:0]        bram_rdata
);

   localparam int PAD_W = 32 - ADDR_WORDS_LOG2 - 2;

   state_t                    state, state_nxt;
   logic                      is_write, is_read, accept;
   logic                      rd_nxt, wr_nxt, rbusy_nxt, wbusy_nxt;
   logic [DATA_W-1:0]         wdata_q;
   logic [DATA_W/BYTE_W-1:0]  wmask_q;
   logic [DATA_W-1:0]         merged;
   logic                      unused_addr_bits;

   // Only the word-index bits reach the BRAM; higher addresses alias.
   assign unused_addr_bits = ^{mem_addr[31:ADDR_WORDS_LOG2+2], mem_addr[1:0]};

   // A store mask wins over a simultaneous read strobe.
   assign is_write = sel && (mem_wmask != '0);
   assign is_read  = sel && mem_rstrb && (mem_wmask == '0);
   assign accept   = (state == IDLE) && (is_write || is_read);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rd_nxt    = 1'b0;
      wr_nxt    = 1'b0;
      rbusy_nxt = 1'b0;
      wbusy_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (is_write) begin
               state_nxt = (mem_wmask == FULL_MASK) ? WR_ISSUE : RMW_RD;
            end else if (is_read) begin
               state_nxt = RD_ISSUE;
            end
         end
         RD_ISSUE:  state_nxt = RD_WAIT;
         RD_WAIT:   state_nxt = IDLE;
         WR_ISSUE:  state_nxt = IDLE;
         RMW_RD:    state_nxt = RMW_MERGE;
         RMW_MERGE: state_nxt = WR_ISSUE;
         default:   state_nxt = IDLE;
      endcase
      // Outputs are registered, so decode them from the state being entered.
      case (state_nxt)
         RD_ISSUE:  begin rd_nxt = 1'b1; rbusy_nxt = 1'b1; end
         RD_WAIT:   rbusy_nxt = 1'b1;
         RMW_RD:    begin rd_nxt = 1'b1; wbusy_nxt = 1'b1; end
         RMW_MERGE: wbusy_nxt = 1'b1;
         WR_ISSUE:  begin wr_nxt = 1'b1; wbusy_nxt = 1'b1; end
         default:   ;
      endcase
   end

   // Request data latch; only consumed by the RMW merge, so no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         wdata_q <= mem_wdata;
         wmask_q <= mem_wmask;
      end
   end

   bram_byte_merge #(
      .DATA_W (DATA_W)
   ) u_merge (
      .old_data (bram_rdata),
      .new_data (wdata_q),
      .mask     (wmask_q),
      .merged   (merged)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_rdata  <= '0;
         mem_rbusy  <= 1'b0;
         mem_wbusy  <= 1'b0;
         bram_addr  <= '0;
         bram_cs    <= 1'b0;
         bram_rd    <= 1'b0;
         bram_wr    <= 1'b0;
         bram_wdata <= '0;
      end else begin
         bram_cs   <= rd_nxt || wr_nxt;
         bram_rd   <= rd_nxt;
         bram_wr   <= wr_nxt;
         mem_rbusy <= rbusy_nxt;
         mem_wbusy <= wbusy_nxt;
         if (accept) begin
            bram_addr <= {{PAD_W{1'b0}}, mem_addr[ADDR_WORDS_LOG2+1:2], 2'b00};
         end
         // Full words go straight out; partial stores load the merged word
         // while the old data is on bram_rdata.
         if (accept && is_write && (mem_wmask == FULL_MASK)) begin
            bram_wdata <= mem_wdata;
         end else if (state == RMW_MERGE) begin
            bram_wdata <= merged;
         end
         if (state == RD_WAIT) begin
            mem_rdata <= bram_rdata;
         end
      end
   end

endmodule

// File: doc/bram_rmw_ctrl.md
Name: bram_rmw_ctrl

Overview:
- Bus-side controller directly upstream of the 32-word on-chip BRAM.
- Accepts femtoRV-style memory requests: mem_rstrb, 4-bit mem_wmask, rbusy/wbusy handshake.
- Drives the BRAM's cs/rd/wr strobes.
- The BRAM writes whole words only, so partial-byte stores are done as read-modify-write (RMW); full-word stores go straight through.

Parameters:
- ADDR_WORDS_LOG2, 5: number of word-address bits forwarded to the BRAM (32 words).
- DATA_W, 32: data width. Fixed at 32; exists only to document widths.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- sel  in  1  address-decode select; the request belongs to this RAM.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  CPU store data, byte lanes aligned.
- mem_wmask  in  4  byte-write enables; non-zero means a write request.
- mem_rstrb  in  1  one-cycle read request pulse.
- mem_rdata  out  32  read data to CPU.
- mem_rbusy  out  1  read in progress.
- mem_wbusy  out  1  write in progress.
- bram_addr  out  32  byte address to BRAM; bits [1:0] are always 0.
- bram_cs  out  1  BRAM chip select.
- bram_rd  out  1  BRAM read strobe.
- bram_wr  out  1  BRAM write strobe.
- bram_wdata  out  32  word written to BRAM.
- bram_rdata  in  32  BRAM read data; valid the cycle after a cs&rd edge.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, resetn).
- Reset values: all outputs 0; state IDLE.
- Registered outputs: every output is registered.
- Request acceptance: only in IDLE, sampled on a rising edge (T0).
  - sel & (mem_wmask != 0) is a write; write wins over a simultaneous mem_rstrb.
  - sel & mem_rstrb & (mem_wmask == 0) is a read.
  - Requests arriving while not IDLE are ignored and not queued. The CPU holds off via busy.
- Request latch: at T0, latch addr[ADDR_WORDS_LOG2+1:2], wdata and wmask.
- Read, states IDLE -> RD_ISSUE -> RD_WAIT -> IDLE:
  - T1: bram_cs=bram_rd=1, mem_rbusy=1.
  - T2: strobes 0, mem_rbusy=1; mem_rdata <= bram_rdata at the end of T2.
  - T3: mem_rbusy=0, mem_rdata valid and held until the next read completes.
- Full write (wmask=4'b1111), states IDLE -> WR_ISSUE -> IDLE:
  - T1: bram_cs=bram_wr=1, bram_wdata=wdata, mem_wbusy=1.
  - T2: mem_wbusy=0.
- Partial write (any other non-zero mask), states IDLE -> RMW_RD -> RMW_MERGE -> WR_ISSUE -> IDLE:
  - T1: cs&rd.
  - T2: merge — byte i = wmask[i] ? wdata byte i : bram_rdata byte i; result registered into bram_wdata.
  - T3: cs&wr.
  - T4: mem_wbusy=0.
  - mem_wbusy is high T1..T3.
  - mem_rdata is not updated by RMW.
- Strobe discipline: bram_rd and bram_wr are never high in the same cycle; bram_cs is high iff either strobe is high.
- Address wrap: bram_addr = {word_addr, 2'b00}, upper bits zero. Address 0x80 aliases word 0.
- Reset mid-operation: all outputs drop immediately (asynchronously). An in-flight RMW is abandoned; if the reset asserts before T3, the BRAM is not written.
- Back-to-back: a new request may be accepted on the rising edge that returns the FSM to IDLE only if the busy output seen by the CPU is already 0. Minimum spacing: read 3 cycles, full write 2 cycles, partial write 4 cycles.

Decomposition:
- Package bram_ctrl_pkg:
  - state encoding: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RMW_RD, RMW_MERGE;
  - FULL_MASK = 4'b1111;
  - BYTE_W = 8.
- Sub-module bram_byte_merge: combinational per-lane mux of wdata and old data under wmask. Reused by the future cache line-fill path.

Test Plan:
- Reset: resetn=0 for 3 cycles with random inputs -> all outputs 0, no bram_cs. Release -> IDLE, busy 0.
- Full write then read: wmask=F, addr=0x14, wdata=0xDEADBEEF -> bram_wr at T1, bram_addr=0x14. Read 0x14 -> mem_rdata=0xDEADBEEF at T3, mem_rbusy high exactly 2 cycles.
- Partial write: preload word 5 (addr 0x14) = 0x11223344; write wmask=4'b0101, wdata=0xAABBCCDD -> BRAM read at T1, write at T3 with 0x11BB33DD; mem_wbusy high 3 cycles.
- Precedence and gating:
  - mem_rstrb=1 with wmask=4'b0010 -> treated as a write, mem_rbusy stays 0.
  - A request with sel=0 -> no bram strobes.
  - A request during busy -> ignored.
- Wrap: full write to 0x80 with 0x0000CAFE -> bram_addr=0x00; a read of 0x00 returns 0x0000CAFE.
- Reset mid-RMW: assert resetn=0 during RMW_MERGE -> bram_wr never asserted, the word keeps its old value, FSM is IDLE after release.
